// File: rtl/fpu_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// then normalise, round and pack. Fixed 27-edge latency, including the special cases.
module fpu_multiplier #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [47:0]        acc_q, acc_d;
  logic [23:0]        man1_q, man1_d, man2_q, man2_d;
  logic [7:0]         e1_q, e1_d, e2_q, e2_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sx_q, sx_d;
  logic [22:0]        mant_q, mant_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic               spec_inv_q, spec_inv_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic               nan1, nan2, inf1, inf2, zero1, zero2, sgn_x;
  logic signed [9:0]  exp_base;
  logic               guard_s, sticky_s, inc_s;
  logic [24:0]        sum_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    man1_d     = man1_q;
    man2_d     = man2_q;
    e1_d       = e1_q;
    e2_d       = e2_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sx_d       = sx_q;
    mant_d     = mant_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_inv_d = spec_inv_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inv_d      = inv_q;

    sgn_x    = operand1[31] ^ operand2[31];
    nan1     = (operand1[30:23] == 8'hFF) && (operand1[22:0] != 23'd0);
    nan2     = (operand2[30:23] == 8'hFF) && (operand2[22:0] != 23'd0);
    inf1     = (operand1[30:23] == 8'hFF) && (operand1[22:0] == 23'd0);
    inf2     = (operand2[30:23] == 8'hFF) && (operand2[22:0] == 23'd0);
    // Denormal inputs are flushed, so a zero exponent alone means zero.
    zero1    = (operand1[30:23] == 8'h00);
    zero2    = (operand2[30:23] == 8'h00);
    exp_base = $signed({2'b00, e1_q}) + $signed({2'b00, e2_q}) - 10'sd127;
    guard_s  = acc_q[22];
    sticky_s = (|acc_q[21:0]) | sx_q;
    inc_s    = (ROUND_MODE == 0) && guard_s && (sticky_s || acc_q[23]);
    sum_s    = {1'b0, acc_q[46:23]} + {24'd0, inc_s};

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d     = 1'b1;
          sign_d     = sgn_x;
          e1_d       = operand1[30:23];
          e2_d       = operand2[30:23];
          man1_d     = {1'b1, operand1[22:0]};
          man2_d     = {1'b1, operand2[22:0]};
          acc_d      = 48'd0;
          cnt_d      = 5'd0;
          sx_d       = 1'b0;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          inv_d      = 1'b0;
          spec_d     = 1'b1;
          spec_inv_d = 1'b0;
          if (nan1 || nan2) begin
            spec_res_d = 32'h7FC0_0000;
          end else if ((inf1 && zero2) || (inf2 && zero1)) begin
            spec_res_d = 32'h7FC0_0000;
            spec_inv_d = 1'b1;
          end else if (inf1 || inf2) begin
            spec_res_d = {sgn_x, 8'hFF, 23'd0};
          end else if (zero1 || zero2) begin
            spec_res_d = {sgn_x, 31'd0};
          end else begin
            spec_d     = 1'b0;
            spec_res_d = 32'd0;
          end
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (man2_q[cnt_q]) acc_d = acc_q + ({24'd0, man1_q} << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = S_NORM;
      end
      S_NORM: begin
        exp_d = exp_base;
        if (acc_q[47]) begin
          // Keep the bit shifted out so it still contributes to sticky.
          acc_d = acc_q >> 1;
          sx_d  = acc_q[0];
          exp_d = exp_base + 10'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (sum_s[24]) begin
          mant_d = sum_s[23:1];
          exp_d  = exp_q + 10'sd1;
        end else begin
          mant_d = sum_s[22:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
        if (spec_q) begin
          result_d = spec_res_q;
          inv_d    = spec_inv_q;
        end else if (exp_q >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (exp_q <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[7:0], mant_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 48'd0;
      man1_q     <= 24'd0;
      man2_q     <= 24'd0;
      e1_q       <= 8'd0;
      e2_q       <= 8'd0;
      sign_q     <= 1'b0;
      exp_q      <= 10'sd0;
      sx_q       <= 1'b0;
      mant_q     <= 23'd0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      spec_inv_q <= 1'b0;
      result_q   <= 32'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      man1_q     <= man1_d;
      man2_q     <= man2_d;
      e1_q       <= e1_d;
      e2_q       <= e2_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sx_q       <= sx_d;
      mant_q     <= mant_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_inv_q <= spec_inv_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inv_q      <= inv_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fpu_multiplier.sv
// Scoreboard bench: two multipliers (round-to-nearest-even and truncate) driven in lockstep,
// checked against an integer-arithmetic IEEE-754 multiply model.
module tb_fpu_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op1, op2;
  logic [31:0] res0, res1;
  logic        done0, done1, busy0, busy1, ov0, ov1, un0, un1, inv0, inv1;

  always #5 clk = ~clk;

  fpu_multiplier #(.ROUND_MODE(0)) dut_rne (
    .clk(clk), .reset(reset), .start(start), .operand1(op1), .operand2(op2),
    .result(res0), .done(done0), .busy(busy0), .overflow(ov0), .underflow(un0), .invalid(inv0));

  fpu_multiplier #(.ROUND_MODE(1)) dut_trn (
    .clk(clk), .reset(reset), .start(start), .operand1(op1), .operand2(op2),
    .result(res1), .done(done1), .busy(busy1), .overflow(ov1), .underflow(un1), .invalid(inv1));

  typedef struct {
    logic [31:0] r;
    logic        ov, un, inv;
  } exp_t;

  typedef struct {
    exp_t        m0, m1;
    time         t;
    logic [31:0] a, b;
  } item_t;

  item_t       sb[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] last0 = 32'd0;
  logic [31:0] last1 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference: exact integer product, then round by comparing the remainder against one half.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t   o;
    logic   s;
    int     ea, eb, e, sh;
    longint p, mant, rem, half;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    o.r = 32'd0; o.ov = 1'b0; o.un = 1'b0; o.inv = 1'b0;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
      o.r = 32'h7FC0_0000;
    end else if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
      o.r = 32'h7FC0_0000;
      o.inv = 1'b1;
    end else if (ea == 255 || eb == 255) begin
      o.r = {s, 8'hFF, 23'd0};
    end else if (ea == 0 || eb == 0) begin
      o.r = {s, 31'd0};
    end else begin
      p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      sh   = (p >= (64'sd1 <<< 47)) ? 24 : 23;
      mant = p >>> sh;
      rem  = p - (mant <<< sh);
      half = 64'sd1 <<< (sh - 1);
      e    = ea + eb - 127 + (sh - 23);
      if (mode == 0 && (rem > half || (rem == half && mant[0]))) mant = mant + 1;
      if (mant == (64'sd1 <<< 24)) begin
        mant = mant >>> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        o.r = {s, 8'hFF, 23'd0};
        o.ov = 1'b1;
      end else if (e <= 0) begin
        o.r = {s, 31'd0};
        o.un = 1'b1;
      end else begin
        o.r = {s, e[7:0], mant[22:0]};
      end
    end
    return o;
  endfunction

  always @(negedge clk) begin
    item_t it;
    if (!reset) begin
      chk("busy_rne", 32'(busy0), 32'(sb.size() != 0));
      chk("busy_trn", 32'(busy1), 32'(sb.size() != 0));
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done0), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("latency", 32'($time - it.t), 32'd275);
          chk("done_trn", 32'(done1), 32'd1);
          chk("result_rne", res0, it.m0.r);
          chk("result_trn", res1, it.m1.r);
          chk("flags_rne", {29'd0, ov0, un0, inv0}, {29'd0, it.m0.ov, it.m0.un, it.m0.inv});
          chk("flags_trn", {29'd0, ov1, un1, inv1}, {29'd0, it.m1.ov, it.m1.un, it.m1.inv});
          last0 = res0;
          last1 = res1;
        end
      end else begin
        chk("hold_rne", res0, last0);
        chk("hold_trn", res1, last1);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    item_t it;
    @(negedge clk);
    start = 1'b1;
    op1 = a;
    op2 = b;
    @(posedge clk);
    it.m0 = model(a, b, 0);
    it.m1 = model(a, b, 1);
    it.t  = $time;
    it.a  = a;
    it.b  = b;
    sb.push_back(it);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    wait_idle();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:0] = 31'd0;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  logic [31:0] dir_a[12] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000,
                             32'h7FC00001, 32'hFF800000, 32'h7F000000, 32'h00800000,
                             32'h80000001, 32'h3F800001, 32'h3FFFFFFF, 32'h7F7FFFFF};
  logic [31:0] dir_b[12] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000,
                             32'h3F800000, 32'h40000000, 32'h7F000000, 32'h00800000,
                             32'h3F800000, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h3F800001};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    #12;
    chk("reset_result", res0, 32'd0);
    chk("reset_outs", {27'd0, done0, busy0, ov0, un0, inv0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run(dir_a[i], dir_b[i]);

    // Start held high through the first op and its done cycle, then stray pulses in MUL.
    issue(32'h40A00000, 32'h3FC00000);
    @(negedge clk);
    op1 = 32'hC1200000;
    op2 = 32'h3E800000;
    for (int i = 0; i < 40 && !done0; i++) @(negedge clk);
    @(posedge clk);
    begin
      item_t it;
      it.m0 = model(32'hC1200000, 32'h3E800000, 0);
      it.m1 = model(32'hC1200000, 32'h3E800000, 1);
      it.t  = $time;
      it.a  = 32'hC1200000;
      it.b  = 32'h3E800000;
      sb.push_back(it);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    op1 = 32'h7F800000;
    op2 = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset asserted in the tenth MUL cycle after a nonzero result is held.
    run(32'h40400000, 32'h40400000);
    issue(32'h3FC00000, 32'h3FC00000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rst_mid_result", res0, 32'd0);
    chk("rst_mid_outs", {27'd0, done0, busy0, ov0, un0, inv0}, 32'd0);
    last0 = 32'd0;
    last1 = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(32'h3FC00000, 32'h3FC00000);

    for (int i = 0; i < 60; i++) run(rand_fp(), rand_fp());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fpu_multiplier.md
Name: fpu_multiplier

Overview:
Multi-cycle IEEE-754 single-precision multiplier in the FPU execute stage, directly downstream of the FPU register file. It takes operand1/operand2 as read from the register file, computes the product with an iterative shift-add datapath, and presents result for the register-file write_data path. The FPU controller pulses start, waits for done, then issues the register write.

Parameters:
ROUND_MODE, 0, 0 = round-to-nearest-even; 1 = truncate (round toward zero)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
operand1  input  32  multiplicand (IEEE-754 single), latched on accepted start
operand2  input  32  multiplier (IEEE-754 single), latched on accepted start
result  output  32  product; held stable from done until next accepted start
done  output  1  one-cycle pulse: result valid
busy  output  1  high from the accepted start until the cycle done is high, inclusive
overflow  output  1  sticky flag for the last operation, updated with done
underflow  output  1  sticky flag for the last operation, updated with done
invalid  output  1  sticky flag for the last operation, updated with done

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: state=IDLE. result, done, busy, overflow, underflow and invalid are all 0. Iteration counter and internal product are 0.
- FSM: IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on start=1, latch both operands, unpack them, clear the 48-bit accumulator and counter, then go to MUL. busy rises on the same edge.
- MUL: exactly 24 cycles. Each cycle: if multiplier bit[cnt] is 1, add the 24-bit mantissa (hidden 1 included), shifted left by cnt, into the 48-bit accumulator. cnt runs 0..23.
- NORM (1 cycle):
  - exp = e1 + e2 - 127, held in a 10-bit signed value.
  - If product bit47 = 1: shift right by 1 and increment exp.
- ROUND (1 cycle):
  - guard = first discarded bit; sticky = OR of the remaining discarded bits.
  - RNE: increment when guard & (sticky | lsb).
  - A mantissa carry-out renormalises: shift right and exp+1.
- DONE (1 cycle): done=1, busy=1, result and flags registered. Next state is IDLE.
- Latency is fixed at 27 edges from the accepting edge to the edge that sets done, for every input including special cases. Special-case values are computed in IDLE and override result in DONE.
- Special cases, in priority order:
  - Either operand is NaN: result 0x7FC00000.
  - inf × zero: result 0x7FC00000, invalid=1.
  - inf × finite nonzero: result is inf with XOR sign.
  - Zero or denormal input: denormals are flushed to zero; result is signed zero with XOR sign.
- Overflow: final exp >= 255 gives result = signed inf, overflow=1. This applies in both rounding modes.
- Underflow: final exp <= 0 gives result = signed zero, underflow=1. No denormal outputs are produced.
- Result sign is always the XOR of the input signs, including zero and inf results.
- start while busy is ignored; there is no queueing. start held high in IDLE right after DONE begins a new operation on that edge.
- Flags cleared on an accepted start; they hold the value written in DONE until the next accepted start.
- Reset mid-operation: immediate return to IDLE with all outputs 0 and no done pulse. The first start after reset deassertion is accepted normally.
- Operands changing after acceptance have no effect on the operation in progress.

Test Plan:
- 0x3FC00000 × 0x40000000 (1.5×2.0) -> result 0x40400000, done exactly 27 edges after start, busy high throughout, all flags 0.
- 0xC0000000 × 0x40400000 (-2×3) -> 0xC0C00000. Then 0x3F800001 × 0x3F800001 -> 0x3F800002 with ROUND_MODE=0, and 0x3F800002 with ROUND_MODE=1 (sticky-only case).
- 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1. 0x7FC00001 × 0x3F800000 -> 0x7FC00000, invalid=0. 0xFF800000 × 0x40000000 -> 0xFF800000.
- 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow=1. 0x00800000 × 0x00800000 -> 0x00000000, underflow=1. 0x80000001 × 0x3F800000 -> 0x80000000, no flags.
- Two back-to-back operations with start held high, plus start pulses during MUL -> extra starts ignored; two done pulses with correct results, each 27 edges after its accepting edge.
- Assert reset at cycle 10 of MUL -> done, busy and result go 0 asynchronously, no done pulse. A new start after release completes correctly.
